lcd_lh507x_ctrl: RTL
====================

// Module: lcd_lh507x_ctrl
// PURPOSE
//  Timing generator and pixel sequencer for the LH507x LCD output stage. Walks a
//  line/frame raster, pulls 2-bit pixels from an upstream stream (valid/ready),
//  and drives the n_/p_ half-cycle signal pairs consumed by lcd_lh507x.
//  p_* is the level for the first half of clk; n_* is the level for the second half.
// PARAMETERS
//  H_TOTAL   228  clk cycles per line
//  H_START   4    first pixel cycle within line (>=2)
//  H_ACTIVE  160  pixels per line (H_START+H_ACTIVE <= H_TOTAL)
//  V_TOTAL   154  lines per frame
//  V_ACTIVE  144  visible lines (< V_TOTAL)
// PORTS
//  clk         in   1  system clock; one cycle per pixel slot
//  reset       in   1  synchronous, active-high
//  disp_on     in   1  1 = run raster; 0 = display off
//  px_valid    in   1  upstream pixel available
//  px_data     in   2  upstream pixel value
//  px_ready    out  1  pixel accepted this cycle when px_valid & px_ready
//  frame_start out  1  1-cycle pulse at h=0, v=0
//  underflow   out  1  1-cycle pulse: pixel slot with px_valid=0
//  {n,p}_hsync, {n,p}_vsync, {n,p}_latch, {n,p}_altsig, {n,p}_ctrl, {n,p}_pclk
//              out  1 each  to lcd_lh507x
//  n_px, p_px  out  2 each  to lcd_lh507x
// BEHAVIOUR
//  - Reset or disp_on=0: h=0, v=0, altsig=0; all outputs 0 next cycle; px_ready=0.
//  - disp_on 0->1: counting starts at (h=0, v=0) on the following cycle.
//  - disp_on 1->0 mid-frame: same as reset next cycle; no partial-line completion.
//  - Counters: h 0..H_TOTAL-1, wraps to 0 and increments v. v 0..V_TOTAL-1, wraps to 0.
//  - Pixel slot: v < V_ACTIVE and H_START <= h < H_START+H_ACTIVE.
//  - px_ready = disp_on & pixel slot (combinational from counters, state in cycle t).
//  - All LCD outputs are registered. Levels for the (h,v) of cycle t appear at t+1.
//    - p_ctrl/n_ctrl = 1 while running.
//    - hsync: 1 (both halves) at h = H_START-1 for v < V_ACTIVE.
//    - latch: 1 (both halves) at h = 0 for 1 <= v <= V_ACTIVE (latches the previous line).
//    - vsync: 1 (both halves) for the whole of line v = 0.
//    - altsig: toggles at h = 0 of every line; same value in both halves.
//    - pclk: p_pclk = 0, n_pclk = 1 in pixel slots; 0 otherwise.
//    - Data: p_px = n_px = accepted px_data in pixel slots; 2'b00 outside slots and on underflow.
//  - Underflow: pixel slot with px_valid=0 outputs 2'b00, pclk still pulses,
//    underflow = 1 for 1 cycle (registered, aligned with the pclk pulse). Raster never stalls.
//  - frame_start is registered, aligned with the first vsync output cycle.
//  - Simultaneous h and v wrap: v goes to 0 and altsig toggles in the same cycle.
// STRUCTURE
//  - Package lcd_lh507x_pkg: default timing constants (H_TOTAL, H_START, H_ACTIVE,
//    V_TOTAL, V_ACTIVE), pixel width = 2.
//  - Sub-module lcd_lh507x_raster: h/v counters plus decoded slot, hsync, latch,
//    vsync and wrap strobes.
//  - Top: output registers, handshake, altsig/underflow logic.
// TESTING
//  1. Reset held 3 cycles with disp_on=1 -> every output 0, px_ready=0. Released:
//     frame_start pulses 1 cycle after the first running cycle.
//  2. Constant px_valid=1, counting px_data -> exactly 160 pclk pulses per visible line
//     and 23040 per frame; data order preserved; no pclk in v >= 144.
//  3. Check edge positions: hsync at h=3 +1 cycle; latch on lines 1..144 only;
//     vsync spans 228 cycles; altsig toggles every 228 cycles.
//  4. px_valid=0 for slots 10..12 of line 5 -> 3 underflow pulses, px=00 on those slots,
//     pclk still pulses, line length unchanged.
//  5. disp_on dropped at v=70, h=100 -> all outputs 0 next cycle. Re-raised -> raster
//     restarts at v=0 with frame_start.
//  6. Small params (H_TOTAL=8, H_START=2, H_ACTIVE=4, V_TOTAL=4, V_ACTIVE=2) ->
//     h/v double-wrap handled, altsig and frame_start periods correct.

Source files
------------

// File: rtl/lcd_lh507x_pkg.sv
// Default LH507x raster timing and pixel width shared by the controller files.
package lcd_lh507x_pkg;
    localparam int H_TOTAL  = 228;
    localparam int H_START  = 4;
    localparam int H_ACTIVE = 160;
    localparam int V_TOTAL  = 154;
    localparam int V_ACTIVE = 144;
    localparam int PX_W     = 2;
endpackage

// File: rtl/lcd_lh507x_raster.sv
// Line/frame position counters with decoded strobes for the current cycle's (h, v).
module lcd_lh507x_raster #(
    parameter int H_TOTAL  = lcd_lh507x_pkg::H_TOTAL,
    parameter int H_START  = lcd_lh507x_pkg::H_START,
    parameter int H_ACTIVE = lcd_lh507x_pkg::H_ACTIVE,
    parameter int V_TOTAL  = lcd_lh507x_pkg::V_TOTAL,
    parameter int V_ACTIVE = lcd_lh507x_pkg::V_ACTIVE
) (
    input  logic clk,
    input  logic run,
    output logic slot,
    output logic hsync,
    output logic latch,
    output logic vsync,
    output logic line_start,
    output logic frame_origin
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0] h;
    logic [VW-1:0] v;

    // Stopping parks the raster at the origin so a restart always begins a fresh frame.
    always_ff @(posedge clk) begin
        if (!run) begin
            h <= '0;
            v <= '0;
        end else if (int'(h) == H_TOTAL - 1) begin
            h <= '0;
            v <= (int'(v) == V_TOTAL - 1) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign slot         = (int'(v) < V_ACTIVE) && (int'(h) >= H_START) &&
                          (int'(h) < H_START + H_ACTIVE);
    assign hsync        = (int'(h) == H_START - 1) && (int'(v) < V_ACTIVE);
    assign line_start   = (h == '0);
    assign latch        = line_start && (int'(v) >= 1) && (int'(v) <= V_ACTIVE);
    assign vsync        = (v == '0);
    assign frame_origin = line_start && vsync;
endmodule

// File: rtl/lcd_lh507x_ctrl.sv
// LH507x timing generator: registers half-cycle level pairs from the raster and pulls pixels.
module lcd_lh507x_ctrl
    import lcd_lh507x_pkg::*;
#(
    parameter int H_TOTAL  = lcd_lh507x_pkg::H_TOTAL,
    parameter int H_START  = lcd_lh507x_pkg::H_START,
    parameter int H_ACTIVE = lcd_lh507x_pkg::H_ACTIVE,
    parameter int V_TOTAL  = lcd_lh507x_pkg::V_TOTAL,
    parameter int V_ACTIVE = lcd_lh507x_pkg::V_ACTIVE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            disp_on,
    input  logic            px_valid,
    input  logic [PX_W-1:0] px_data,
    output logic            px_ready,
    output logic            frame_start,
    output logic            underflow,
    output logic            n_hsync,
    output logic            p_hsync,
    output logic            n_vsync,
    output logic            p_vsync,
    output logic            n_latch,
    output logic            p_latch,
    output logic            n_altsig,
    output logic            p_altsig,
    output logic            n_ctrl,
    output logic            p_ctrl,
    output logic            n_pclk,
    output logic            p_pclk,
    output logic [PX_W-1:0] n_px,
    output logic [PX_W-1:0] p_px
);
    logic run;
    logic slot, hsync_d, latch_d, vsync_d, line_start, frame_origin;
    logic hsync_q, vsync_q, latch_q, altsig_q, ctrl_q, pclk_q;
    logic [PX_W-1:0] px_q;

    assign run = disp_on && !reset;

    lcd_lh507x_raster #(
        .H_TOTAL (H_TOTAL),
        .H_START (H_START),
        .H_ACTIVE(H_ACTIVE),
        .V_TOTAL (V_TOTAL),
        .V_ACTIVE(V_ACTIVE)
    ) u_raster (
        .clk         (clk),
        .run         (run),
        .slot        (slot),
        .hsync       (hsync_d),
        .latch       (latch_d),
        .vsync       (vsync_d),
        .line_start  (line_start),
        .frame_origin(frame_origin)
    );

    assign px_ready = run && slot;

    always_ff @(posedge clk) begin
        if (!run) begin
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            latch_q     <= 1'b0;
            altsig_q    <= 1'b0;
            ctrl_q      <= 1'b0;
            pclk_q      <= 1'b0;
            px_q        <= '0;
            underflow   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            latch_q     <= latch_d;
            altsig_q    <= line_start ? !altsig_q : altsig_q;
            ctrl_q      <= 1'b1;
            pclk_q      <= slot;
            // A starved slot still clocks the panel, with blank data.
            px_q        <= (slot && px_valid) ? px_data : '0;
            underflow   <= slot && !px_valid;
            frame_start <= frame_origin;
        end
    end

    assign p_hsync  = hsync_q;
    assign n_hsync  = hsync_q;
    assign p_vsync  = vsync_q;
    assign n_vsync  = vsync_q;
    assign p_latch  = latch_q;
    assign n_latch  = latch_q;
    assign p_altsig = altsig_q;
    assign n_altsig = altsig_q;
    assign p_ctrl   = ctrl_q;
    assign n_ctrl   = ctrl_q;
    assign p_pclk   = 1'b0;
    assign n_pclk   = pclk_q;
    assign p_px     = px_q;
    assign n_px     = px_q;
endmodule
